// File: rtl/mux_func_bist.sv
// BIST sequencer for a 3-select/1-data mux function unit.
// Sweeps all 16 input vectors and compares y against an expected table.
module mux_func_bist #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter bit          STOP_ON_FAIL  = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] exp_tt,
   input  logic        y_in,
   output logic        s0,
   output logic        s1,
   output logic        s2,
   output logic        d,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] tt_out,
   output logic [4:0]  fail_cnt,
   output logic [3:0]  first_fail
);

   typedef enum logic [1:0] {
      IDLE,
      APPLY,
      SAMPLE,
      FINISH
   } state_t;

   state_t      state;
   state_t      nxt;
   logic [3:0]  idx;
   logic [3:0]  vec;
   logic [7:0]  cnt;
   logic [15:0] exp_q;
   logic        mis;
   logic        last;
   logic        settled;

   assign mis     = y_in != exp_q[idx];
   assign last    = (idx == 4'd15) || (STOP_ON_FAIL && mis);
   assign settled = cnt == 8'(SETTLE_CYCLES - 1);

   assign {s0, s1, s2, d} = vec;
   assign busy = state != IDLE;
   assign done = state == FINISH;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = APPLY;
         APPLY:   if (settled) nxt = SAMPLE;
         SAMPLE:  nxt = last ? FINISH : APPLY;
         FINISH:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (abort) nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         vec        <= '0;
         cnt        <= '0;
         exp_q      <= '0;
         pass       <= 1'b0;
         tt_out     <= '0;
         fail_cnt   <= '0;
         first_fail <= '0;
      end else begin
         state <= nxt;
         if (abort) begin
            // partial table and count are kept for inspection
            vec <= '0;
            cnt <= '0;
            if (state != IDLE) pass <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     exp_q      <= exp_tt;
                     tt_out     <= '0;
                     fail_cnt   <= '0;
                     first_fail <= '0;
                     pass       <= 1'b0;
                     idx        <= '0;
                     vec        <= '0;
                     cnt        <= '0;
                  end
               end
               APPLY: begin
                  cnt <= settled ? 8'd0 : cnt + 8'd1;
               end
               SAMPLE: begin
                  tt_out[idx] <= y_in;
                  if (mis) begin
                     fail_cnt <= fail_cnt + 5'd1;
                     if (fail_cnt == 5'd0) first_fail <= idx;
                  end
                  if (last) begin
                     vec  <= '0;
                     pass <= (fail_cnt == 5'd0) && !mis;
                  end else begin
                     idx <= idx + 4'd1;
                     vec <= idx + 4'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mux_func_bist.sv
// Directed bench for mux_func_bist: three instances cover
// settle=1, settle=4 and stop-on-fail.
module tb_mux_func_bist;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] exp_tt;
   logic [15:0] gold;
   int          fault;

   logic [3:0]  v [3];
   logic        y [3];
   logic        busy [3];
   logic        done [3];
   logic        pass [3];
   logic [15:0] tt [3];
   logic [4:0]  fc [3];
   logic [3:0]  ff [3];

   int n_cmp = 0;
   int n_err = 0;

   int          dcnt [3];
   int          dcyc [3];
   logic [3:0]  v0r [0:127];
   logic [3:0]  v1r [0:127];
   logic        b0r [0:127];

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         case (fault)
            1:       y[k] = 1'b0;
            2:       y[k] = (v[k] == 4'd5) ? 1'b0 : gold[v[k]];
            default: y[k] = gold[v[k]];
         endcase
      end
   end

   mux_func_bist #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b0)) u0 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .exp_tt(exp_tt), .y_in(y[0]),
      .s0(v[0][3]), .s1(v[0][2]), .s2(v[0][1]), .d(v[0][0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .tt_out(tt[0]), .fail_cnt(fc[0]), .first_fail(ff[0])
   );

   mux_func_bist #(.SETTLE_CYCLES(4), .STOP_ON_FAIL(1'b0)) u1 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .exp_tt(exp_tt), .y_in(y[1]),
      .s0(v[1][3]), .s1(v[1][2]), .s2(v[1][1]), .d(v[1][0]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .tt_out(tt[1]), .fail_cnt(fc[1]), .first_fail(ff[1])
   );

   mux_func_bist #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b1)) u2 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .exp_tt(exp_tt), .y_in(y[2]),
      .s0(v[2][3]), .s1(v[2][2]), .s2(v[2][1]), .d(v[2][0]),
      .busy(busy[2]), .done(done[2]), .pass(pass[2]),
      .tt_out(tt[2]), .fail_cnt(fc[2]), .first_fail(ff[2])
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // start pulse at cycle 0; optional one-cycle abort/start/rst at cycle c
   task automatic sweep(input int ncyc, input int ab_c,
                        input int st_c, input int rs_c);
      for (int k = 0; k < 3; k++) begin
         dcnt[k] = 0;
         dcyc[k] = 0;
      end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= ncyc; c++) begin
         if (c < 128) begin
            v0r[c] = v[0];
            v1r[c] = v[1];
            b0r[c] = busy[0];
         end
         for (int k = 0; k < 3; k++) begin
            if (done[k]) begin
               if (dcnt[k] == 0) dcyc[k] = c;
               dcnt[k]++;
            end
         end
         abort = (c == ab_c);
         start = (c == st_c);
         rst   = (c == rs_c);
         @(negedge clk);
      end
      abort = 1'b0;
      start = 1'b0;
      rst   = 1'b0;
   endtask

   int e0;
   int e1;

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      abort  = 1'b0;
      exp_tt = 16'hE3BB;
      gold   = 16'hE3BB;
      fault  = 0;
      repeat (3) @(negedge clk);
      check("rst_busy_done", {busy[0], done[0], pass[0]}, 3'b000);
      check("rst_tt_fc_ff", {tt[0], 3'b0, fc[0], 4'b0, ff[0]}, 32'h0);
      check("rst_vec", v[0], 4'h0);
      rst = 1'b0;

      // golden sweep
      sweep(90, 0, 0, 0);
      check("t1_done_cyc", dcyc[0], 33);
      check("t1_done_cnt", dcnt[0], 1);
      check("t1_pass", pass[0], 1'b1);
      check("t1_tt", tt[0], 16'hE3BB);
      check("t1_fc", fc[0], 5'd0);
      check("t1_busy1", b0r[1], 1'b1);
      check("t1_s4_done_cyc", dcyc[1], 81);
      check("t1_s4_pass", pass[1], 1'b1);
      e0 = 0;
      e1 = 0;
      for (int c = 1; c <= 32; c++)
         if (v0r[c] != 4'((c - 1) / 2)) e0++;
      for (int c = 1; c <= 80; c++)
         if (v1r[c] != 4'((c - 1) / 5)) e1++;
      check("t6_order_s1", e0, 0);
      check("t6_order_s4", e1, 0);

      // stuck-at-0 unit
      fault = 1;
      sweep(40, 0, 0, 0);
      check("t2_pass", pass[0], 1'b0);
      check("t2_fc", fc[0], 5'd11);
      check("t2_ff", ff[0], 4'd0);
      check("t2_tt", tt[0], 16'h0000);
      check("t2_done_cyc", dcyc[0], 33);

      // stop on first fail at vector 5
      fault  = 2;
      exp_tt = 16'h003F;
      gold   = 16'h003F;
      sweep(40, 0, 0, 0);
      check("t3_done_cyc", dcyc[2], 13);
      check("t3_fc", fc[2], 5'd1);
      check("t3_ff", ff[2], 4'd5);
      check("t3_tt", tt[2], 16'h001F);
      check("t3_pass", pass[2], 1'b0);
      check("t3_nostop_fc", fc[0], 5'd1);

      // abort while idx=7, then a clean sweep
      fault  = 0;
      exp_tt = 16'hE3BB;
      gold   = 16'hE3BB;
      sweep(40, 15, 0, 0);
      check("t4_vec_at_abort", v0r[15], 4'd7);
      check("t4_busy_after", b0r[16], 1'b0);
      check("t4_vec_after", v0r[16], 4'd0);
      check("t4_no_done", dcnt[0], 0);
      check("t4_pass", pass[0], 1'b0);
      check("t4_partial_tt", tt[0], 16'h003B);
      sweep(40, 0, 0, 0);
      check("t4_clean_done", dcyc[0], 33);
      check("t4_clean_tt", tt[0], 16'hE3BB);
      check("t4_clean_pass", pass[0], 1'b1);

      // start while busy is ignored
      sweep(40, 0, 10, 0);
      check("t5_one_done", dcnt[0], 1);
      check("t5_done_cyc", dcyc[0], 33);

      // rst mid-sweep
      sweep(40, 0, 0, 20);
      check("t5_rst_no_done", dcnt[0], 0);
      check("t5_rst_busy", b0r[21], 1'b0);
      check("t5_rst_outs", {tt[0], fc[0], ff[0], pass[0], busy[0], done[0]},
            32'h0);
      check("t5_rst_vec", v[0], 4'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
